char_buffer_writer: RTL and testbench

- Upstream neighbour of the 80x24 video generator.
- Accepts a byte stream (valid/ready) and writes printable characters into the dual-port char buffer write port.
- Interprets CR/LF/BS control codes, owns the cursor position, and implements hardware scrolling by advancing first_char around the circular buffer.
- Drives cursor_x, cursor_y and first_char straight into the video generator.

---
 rtl/char_buffer_writer.sv | 181 ++++++++++++++++++
 tb/tb_char_buffer_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_writer.sv
// Byte-stream front end for the 80x24 text display: writes printable bytes into the char buffer and handles CR/LF/BS plus scrolling.
// Optional TAB handling (0x09) is enabled by defining CHAR_BUFFER_WRITER_TAB_EN.
module char_buffer_writer #(
  parameter int ROWS          = 24,
  parameter int COLS          = 80,
  parameter int ROW_BITS      = 5,
  parameter int COL_BITS      = 7,
  parameter int ADDR_BITS     = 11,
  parameter int PAST_LAST_ROW = ROWS * COLS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [COL_BITS-1:0]  cursor_x,
  output logic [ROW_BITS-1:0]  cursor_y,
  output logic [ADDR_BITS-1:0] first_char,
  output logic [ADDR_BITS-1:0] buf_wr_addr,
  output logic [7:0]           buf_wr_data,
  output logic                 buf_wr_en,
  output logic [1:0]           state_dbg_o
);

  // Handshake: a byte transfers on a rising edge where data_valid && data_ready;
  // data_ready is registered and only ever high while the FSM sits in IDLE.

  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    IDLE       = 2'd1,
    CLEAR_LINE = 2'd2
  } state_e;

  localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PAST_LAST_ROW - 1);
  localparam logic [ADDR_BITS-1:0] PAST_ADDR = ADDR_BITS'(PAST_LAST_ROW);
  localparam logic [ADDR_BITS-1:0] COLS_A    = ADDR_BITS'(COLS);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [COL_BITS-1:0]  cursor_x_q, cursor_x_d;
  logic [ROW_BITS-1:0]  cursor_y_q, cursor_y_d;
  logic [ADDR_BITS-1:0] first_char_q, first_char_d;
  logic [ADDR_BITS-1:0] row_addr_q, row_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 ready_q, ready_d;
  logic                 accept;

  // Row addresses are multiples of COLS, so one step forward can only land exactly on the end.
  function automatic logic [ADDR_BITS-1:0] next_row(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS-1:0] s;
    s = a + COLS_A;
    return (s == PAST_ADDR) ? '0 : s;
  endfunction

`ifdef CHAR_BUFFER_WRITER_TAB_EN
  logic [COL_BITS:0] tab_next;
  always_comb begin
    tab_next = {1'b0, cursor_x_q[COL_BITS-1:3], 3'b000} + (COL_BITS+1)'(8);
  end
`endif

  assign accept = data_valid && ready_q && (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    first_char_d = first_char_q;
    row_addr_d   = row_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    ready_d      = 1'b0;

    case (state_q)
      CLEAR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = 8'h20;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CLEAR_LINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_addr_q + cnt_q;
        wr_data_d = 8'h20;
        if (cnt_q == ADDR_BITS'(COLS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (data_in >= 8'h20 && data_in <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_addr_q + ADDR_BITS'(cursor_x_q);
            wr_data_d = data_in;
            if (cursor_x_q != LAST_COL) cursor_x_d = cursor_x_q + 1'b1;
          end else begin
            case (data_in)
              8'h0D: cursor_x_d = '0;
              8'h08: if (cursor_x_q != '0) cursor_x_d = cursor_x_q - 1'b1;
              8'h0A: begin
                row_addr_d = next_row(row_addr_q);
                if (cursor_y_q != LAST_ROW) begin
                  cursor_y_d = cursor_y_q + 1'b1;
                end else begin
                  // Scroll: the new bottom line reuses the storage of the old top line.
                  first_char_d = next_row(first_char_q);
                  state_d      = CLEAR_LINE;
                  cnt_d        = '0;
                  ready_d      = 1'b0;
                end
              end
`ifdef CHAR_BUFFER_WRITER_TAB_EN
              8'h09: cursor_x_d = (tab_next > {1'b0, LAST_COL}) ? LAST_COL
                                                                : tab_next[COL_BITS-1:0];
`endif
              default: ;
            endcase
          end
        end
      end

      default: begin
        state_d = CLEAR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR_ALL;
      cnt_q        <= '0;
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
      first_char_q <= '0;
      row_addr_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h20;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      first_char_q <= first_char_d;
      row_addr_q   <= row_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      ready_q      <= ready_d;
    end
  end

  assign data_ready  = ready_q;
  assign cursor_x    = cursor_x_q;
  assign cursor_y    = cursor_y_q;
  assign first_char  = first_char_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_char_buffer_writer.sv
// Directed bench for char_buffer_writer: full clear, printing, control codes, scrolling, wrap and TAB.
module tb_char_buffer_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [10:0] first_char;
  logic [10:0] buf_wr_addr;
  logic [7:0]  buf_wr_data;
  logic        buf_wr_en;
  logic [1:0]  state_dbg_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:2047];

  char_buffer_writer dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .first_char(first_char), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_wr_en(buf_wr_en), .state_dbg_o(state_dbg_o)
  );

  always #10 clk = ~clk;

  // Model of the char buffer RAM, fed by the write port.
  always @(posedge clk) if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (data_ready !== 1'b1 && n < 3000) begin tick; n++; end
    checks++;
    if (data_ready !== 1'b1) begin
      errors++; $display("FAIL send_timeout byte=%h ready=%b required 1", b, data_ready);
    end
    data_in = b; data_valid = 1'b1;
    tick;
    data_valid = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) tick;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", data_ready); end
    checks++; if (buf_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", buf_wr_en); end
    checks++; if (buf_wr_addr !== 11'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", buf_wr_addr); end
    checks++; if (buf_wr_data !== 8'h20) begin errors++; $display("FAIL rst_data got %h exp 20", buf_wr_data); end
    checks++; if ({cursor_x, cursor_y} !== 12'd0) begin errors++; $display("FAIL rst_cursor got %0d,%0d exp 0,0", cursor_x, cursor_y); end
    checks++; if (first_char !== 11'd0) begin errors++; $display("FAIL rst_first got %0d exp 0", first_char); end
    checks++; if (state_dbg_o !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg_o); end
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 1920; k++) begin
      tick;
      if (!(buf_wr_en === 1'b1 && buf_wr_addr === 11'(k) && buf_wr_data === 8'h20 && data_ready === 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_all_sweep bad_cycles %0d exp 0", bad); end
    tick;
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL clear_done_ready got %b exp 1", data_ready); end
    checks++; if (buf_wr_en !== 1'b0) begin errors++; $display("FAIL clear_done_wr_en got %b exp 0", buf_wr_en); end
    checks++; if (state_dbg_o !== 2'd1) begin errors++; $display("FAIL clear_done_state got %0d exp 1", state_dbg_o); end
    bad = 0;
    for (int a = 0; a < 1920; a++) if (mem[a] !== 8'h20) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_all_mem bad_cells %0d exp 0", bad); end
  endtask

  task automatic test_print_ab;
    send_byte(8'h41);
    checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 11'd0 || buf_wr_data !== 8'h41) begin
      errors++; $display("FAIL write_A got en=%b addr=%0d data=%h exp 1,0,41", buf_wr_en, buf_wr_addr, buf_wr_data); end
    checks++; if (cursor_x !== 7'd1) begin errors++; $display("FAIL cx_after_A got %0d exp 1", cursor_x); end
    send_byte(8'h42);
    checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 11'd1 || buf_wr_data !== 8'h42) begin
      errors++; $display("FAIL write_B got en=%b addr=%0d data=%h exp 1,1,42", buf_wr_en, buf_wr_addr, buf_wr_data); end
    checks++; if (cursor_x !== 7'd2) begin errors++; $display("FAIL cx_after_B got %0d exp 2", cursor_x); end
    tick;
    checks++; if (buf_wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_one_cycle got %b exp 0", buf_wr_en); end
    checks++; if (mem[0] !== 8'h41 || mem[1] !== 8'h42) begin errors++; $display("FAIL mem_AB got %h %h exp 41 42", mem[0], mem[1]); end
  endtask

  task automatic test_saturate;
    send_byte(8'h0D);
    checks++; if (cursor_x !== 7'd0 || buf_wr_en !== 1'b0) begin errors++; $display("FAIL cr_row0 got x=%0d en=%b exp 0,0", cursor_x, buf_wr_en); end
    for (int i = 0; i < 82; i++) send_byte(8'(8'h21 + i));
    checks++; if (cursor_x !== 7'd79) begin errors++; $display("FAIL sat_cx got %0d exp 79", cursor_x); end
    checks++; if (buf_wr_addr !== 11'd79 || buf_wr_data !== 8'h72) begin errors++; $display("FAIL sat_last_write got %0d,%h exp 79,72", buf_wr_addr, buf_wr_data); end
    tick;
    checks++; if (mem[79] !== 8'h72 || mem[78] !== 8'h6F || mem[0] !== 8'h21) begin
      errors++; $display("FAIL sat_mem got %h %h %h exp 72 6f 21", mem[79], mem[78], mem[0]); end
  endtask

  task automatic test_ctrl;
    send_byte(8'h0D);
    for (int i = 0; i < 5; i++) send_byte(8'h78);
    checks++; if (cursor_x !== 7'd5) begin errors++; $display("FAIL ctrl_x5 got %0d exp 5", cursor_x); end
    send_byte(8'h0D);
    checks++; if (cursor_x !== 7'd0 || buf_wr_en !== 1'b0) begin errors++; $display("FAIL ctrl_cr got x=%0d en=%b exp 0,0", cursor_x, buf_wr_en); end
    send_byte(8'h0A);
    checks++; if (cursor_y !== 5'd1 || cursor_x !== 7'd0 || first_char !== 11'd0) begin
      errors++; $display("FAIL ctrl_lf got y=%0d x=%0d fc=%0d exp 1,0,0", cursor_y, cursor_x, first_char); end
    send_byte(8'h5A);
    checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 11'd80 || buf_wr_data !== 8'h5A) begin
      errors++; $display("FAIL ctrl_row1_write got en=%b addr=%0d data=%h exp 1,80,5a", buf_wr_en, buf_wr_addr, buf_wr_data); end
    send_byte(8'h08);
    checks++; if (cursor_x !== 7'd0) begin errors++; $display("FAIL ctrl_bs got %0d exp 0", cursor_x); end
    send_byte(8'h08);
    checks++; if (cursor_x !== 7'd0) begin errors++; $display("FAIL ctrl_bs_at0 got %0d exp 0", cursor_x); end
    send_byte(8'h07);
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd1 || buf_wr_en !== 1'b0 || data_ready !== 1'b1) begin
      errors++; $display("FAIL ctrl_discard got x=%0d y=%0d en=%b rdy=%b exp 0,1,0,1", cursor_x, cursor_y, buf_wr_en, data_ready); end
  endtask

  task automatic test_scroll;
    int bad;
    for (int i = 0; i < 22; i++) send_byte(8'h0A);
    checks++; if (cursor_y !== 5'd23 || first_char !== 11'd0) begin errors++; $display("FAIL y23 got y=%0d fc=%0d exp 23,0", cursor_y, first_char); end
    send_byte(8'h0A);
    checks++; if (cursor_y !== 5'd23 || first_char !== 11'd80) begin errors++; $display("FAIL scroll1 got y=%0d fc=%0d exp 23,80", cursor_y, first_char); end
    checks++; if (data_ready !== 1'b0 || state_dbg_o !== 2'd2) begin errors++; $display("FAIL scroll_state got rdy=%b st=%0d exp 0,2", data_ready, state_dbg_o); end
    data_in = 8'h51; data_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      tick;
      if (!(buf_wr_en === 1'b1 && buf_wr_addr === 11'(k) && buf_wr_data === 8'h20 && data_ready === 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_line_sweep bad_cycles %0d exp 0", bad); end
    tick;
    checks++; if (data_ready !== 1'b1 || buf_wr_en !== 1'b0 || state_dbg_o !== 2'd1) begin
      errors++; $display("FAIL clear_line_done got rdy=%b en=%b st=%0d exp 1,0,1", data_ready, buf_wr_en, state_dbg_o); end
    tick;
    data_valid = 1'b0;
    checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 11'd0 || buf_wr_data !== 8'h51 || cursor_x !== 7'd1) begin
      errors++; $display("FAIL held_byte got en=%b addr=%0d data=%h x=%0d exp 1,0,51,1", buf_wr_en, buf_wr_addr, buf_wr_data, cursor_x); end
    tick;
    checks++; if (mem[0] !== 8'h51 || mem[1] !== 8'h20 || mem[79] !== 8'h20) begin
      errors++; $display("FAIL clear_line_mem got %h %h %h exp 51 20 20", mem[0], mem[1], mem[79]); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 22; i++) send_byte(8'h0A);
    checks++; if (first_char !== 11'd1840 || cursor_y !== 5'd23) begin errors++; $display("FAIL fc_1840 got %0d y=%0d exp 1840,23", first_char, cursor_y); end
    send_byte(8'h0A);
    checks++; if (first_char !== 11'd0) begin errors++; $display("FAIL fc_wrap got %0d exp 0", first_char); end
    send_byte(8'h57);
    checks++; if (buf_wr_addr !== 11'd1841 || buf_wr_data !== 8'h57 || cursor_x !== 7'd2) begin
      errors++; $display("FAIL wrap_write got addr=%0d data=%h x=%0d exp 1841,57,2", buf_wr_addr, buf_wr_data, cursor_x); end
    tick;
    checks++; if (mem[1841] !== 8'h57 || mem[1842] !== 8'h20 || mem[1919] !== 8'h20) begin
      errors++; $display("FAIL wrap_mem got %h %h %h exp 57 20 20", mem[1841], mem[1842], mem[1919]); end
  endtask

  task automatic test_tab;
    send_byte(8'h0D);
    for (int i = 0; i < 3; i++) send_byte(8'h61);
    checks++; if (cursor_x !== 7'd3) begin errors++; $display("FAIL tab_setup got %0d exp 3", cursor_x); end
    send_byte(8'h09);
`ifdef CHAR_BUFFER_WRITER_TAB_EN
    checks++; if (cursor_x !== 7'd8 || buf_wr_en !== 1'b0) begin errors++; $display("FAIL tab_3 got x=%0d en=%b exp 8,0", cursor_x, buf_wr_en); end
    send_byte(8'h09);
    checks++; if (cursor_x !== 7'd16) begin errors++; $display("FAIL tab_8 got %0d exp 16", cursor_x); end
    for (int i = 0; i < 7; i++) send_byte(8'h09);
    checks++; if (cursor_x !== 7'd72) begin errors++; $display("FAIL tab_72 got %0d exp 72", cursor_x); end
    send_byte(8'h09);
    checks++; if (cursor_x !== 7'd79) begin errors++; $display("FAIL tab_clamp got %0d exp 79", cursor_x); end
    send_byte(8'h09);
    checks++; if (cursor_x !== 7'd79) begin errors++; $display("FAIL tab_79 got %0d exp 79", cursor_x); end
`else
    checks++; if (cursor_x !== 7'd3 || buf_wr_en !== 1'b0) begin errors++; $display("FAIL tab_ignored got x=%0d en=%b exp 3,0", cursor_x, buf_wr_en); end
`endif
  endtask

  task automatic test_reset_abort;
    send_byte(8'h0A);
    repeat (5) tick;
    checks++; if (state_dbg_o !== 2'd2) begin errors++; $display("FAIL abort_pre_state got %0d exp 2", state_dbg_o); end
    reset = 1'b1;
    tick;
    checks++; if (state_dbg_o !== 2'd0 || data_ready !== 1'b0 || buf_wr_en !== 1'b0) begin
      errors++; $display("FAIL abort_state got st=%0d rdy=%b en=%b exp 0,0,0", state_dbg_o, data_ready, buf_wr_en); end
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0 || first_char !== 11'd0 || buf_wr_addr !== 11'd0 || buf_wr_data !== 8'h20) begin
      errors++; $display("FAIL abort_regs got x=%0d y=%0d fc=%0d addr=%0d data=%h exp 0,0,0,0,20",
                         cursor_x, cursor_y, first_char, buf_wr_addr, buf_wr_data); end
    reset = 1'b0;
    tick;
    checks++; if (buf_wr_en !== 1'b1 || buf_wr_addr !== 11'd0 || state_dbg_o !== 2'd0) begin
      errors++; $display("FAIL abort_restart got en=%b addr=%0d st=%0d exp 1,0,0", buf_wr_en, buf_wr_addr, state_dbg_o); end
  endtask

  initial begin
    test_reset;
    test_print_ab;
    test_saturate;
    test_ctrl;
    test_scroll;
    test_wrap;
    test_tab;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
